sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the onboard 512Kx16 asynchronous SRAM between two 8-bit byte requesters.
- Port A is the CPU program-RAM path. Port B is a secondary master, such as a loader or video/DMA.
- Sequences the SRAM read and write cycles: address setup, write-enable pulse, data hold and byte-lane select.
- Replaces direct CPU wiring of sram_a/sram_d/sram_wel/sram_lbl/sram_ubl in the top level.

Parameters:
- wait_states, 1, extra clock cycles added to each read-access and write-pulse phase. Range 0..7. At 25 MHz the default gives an 80 ns access.

Ports:
- clk  in  1  system clock (clk_pixel domain)
- n_reset  in  1  reset, synchronous, active-low
- a_req  in  1  port A request; level-held until ack
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  20  port A byte address
- a_wdata  in  8  port A write data
- a_rdata  out  8  port A read data, registered
- a_ack  out  1  port A one-cycle completion pulse
- b_req, b_we, b_addr[19:0], b_wdata[7:0], b_rdata[7:0], b_ack: same as port A, for port B
- sram_a  out  19  SRAM word address
- sram_d  inout  16  SRAM data bus; driven only during write phases
- sram_wel  out  1  write enable, active-low
- sram_lbl  out  1  lower byte enable, active-low
- sram_ubl  out  1  upper byte enable, active-low

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset is n_reset, synchronous and active-low.
- All SRAM outputs and all ack/rdata outputs are registered.

Reset values (n_reset=0 at a clk edge):
- state=IDLE, sram_wel=1, sram_lbl=1, sram_ubl=1.
- sram_d tristated, sram_a=0.
- a_ack=b_ack=0, a_rdata=b_rdata=0.
- last_grant=B, so port A wins the first tie.
- Reset mid-operation aborts immediately at that edge. A write pulse is truncated, no ack is issued, and the requester must re-issue.

States:
- IDLE → RD or WS when any req is sampled high.
- RD: W+1 cycles, where W=wait_states.
- WS: write setup, 1 cycle.
- WP: write pulse, W+1 cycles.
- WH: write hold, 1 cycle.
- DONE: 1 cycle, then → IDLE.

Arbitration (IDLE only):
- Only one requester high: grant it.
- Both high: grant the port not equal to last_grant (round-robin).
- last_grant is updated on grant.
- The granted port's we/addr/wdata are latched at the grant edge. Requester inputs may change afterwards without effect.

Addressing and lanes:
- sram_a = addr[19:1].
- addr[0]=0 selects the lower byte: lbl=0, lane sram_d[7:0].
- addr[0]=1 selects the upper byte: ubl=0, lane sram_d[15:8].
- The unselected lane enable stays 1.

Read:
- RD: address and byte enable asserted, wel=1, bus tristated.
- At the edge leaving RD, the selected lane is captured into the granted port's rdata.
- DONE: enables deasserted, ack=1 for the granted port.
- The ack cycle begins W+2 cycles after the grant edge.
- rdata holds its value until the next read completes on the same port.

Write:
- WS: address, byte enable and sram_d={wdata,wdata} driven, wel=1.
- WP: wel=0.
- WH: wel=1, data and address still driven.
- DONE: bus tristated, enables high, ack=1.
- The ack cycle begins W+4 cycles after the grant edge.
- Address and data are stable for the whole time wel=0.

Handshake:
- ack is exactly one cycle wide, and only for the granted port.
- The requester drops req at the edge where it samples ack=1. A req still high in IDLE starts a new access.
- The non-granted requester waits with req held. Its ack stays 0.

Bus safety:
- sram_d is driven only in WS, WP and WH.
- wel is never 0 outside WP.

Test Plan:
- W=1, A reads addr 0x00004 after the SRAM model has been preloaded with word 2=0xBEEF. Required: sram_a=2 and lbl=0, ubl=1 during RD; a_rdata=0xEF; a_ack high exactly 3 cycles after the grant edge.
- A writes 0x5A to addr 0x00007. Required: sram_a=3, ubl=0, lbl=1; wel=0 for 2 cycles, bracketed by 1-cycle setup and hold with sram_d=0x5A5A; ack at grant+5. A subsequent read of 0x00007 returns 0x5A, and lower byte 0x00006 is unchanged.
- A and B both request from reset, each re-requesting continuously. Required: grants alternate A,B,A,B; each ack goes only to its own port; b_rdata is unaffected by A reads.
- Only B requests repeatedly. Required: B is granted each time with no idle bubble beyond DONE→IDLE. After that, A and B assert req together with last_grant=B; A is granted first.
- n_reset=0 during WP. Required: at that edge wel=1, lbl=ubl=1, sram_d=Z, no ack, state IDLE; a re-issued request completes normally.
- W=0 and W=3 sweep: read ack at grant+2/+5, write ack at grant+4/+7; wel low for W+1 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one 512Kx16 asynchronous SRAM between two byte-wide requesters.
// Port A is the CPU program-RAM path; port B is a secondary master (loader,
// video or DMA). Each granted access runs a fixed-length bus sequence:
//   read : RD (W+1 cycles) -> DONE
//   write: WS (1) -> WP (W+1, wel low) -> WH (1) -> DONE
// where W = wait_states. DONE carries the one-cycle ack and always returns
// to IDLE. When both ports request in IDLE, the port that did not win last
// time is granted.
//
// Ports
//   clk, n_reset                 clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata    port A request, level-held until a_ack
//   a_rdata, a_ack               port A read data (registered), done pulse
//   b_*                          same as port A, for port B
//   sram_a                       SRAM word address (byte address [19:1])
//   sram_d                       SRAM data bus, driven only while writing
//   sram_wel, sram_lbl, sram_ubl SRAM write / lower / upper enables, active-low
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int unsigned wait_states = 1  // 0..7
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [19:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [19:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [18:0] sram_a,
  inout  wire  [15:0] sram_d,
  output logic        sram_wel,
  output logic        sram_lbl,
  output logic        sram_ubl
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WS   = 3'd2;
  localparam logic [2:0] S_WP   = 3'd3;
  localparam logic [2:0] S_WH   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [2:0] WAIT_LAST = 3'(wait_states);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        port_q, port_d;            // port owning the current access
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [18:0] sram_a_q, sram_a_d;
  logic        wel_q, wel_d;
  logic        lbl_q, lbl_d;
  logic        ubl_q, ubl_d;
  logic        d_oe_q, d_oe_d;
  logic [15:0] d_out_q, d_out_d;

  logic        grant_b;
  logic [7:0]  lane;
  logic        bus_active;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    grant_b      = 1'b0;
    lane         = addr_q[0] ? sram_d[15:8] : sram_d[7:0];

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // B wins only when A is idle or A had the previous grant.
          grant_b      = b_req && (!a_req || (last_grant_q == PORT_A));
          port_d       = grant_b;
          last_grant_d = grant_b;
          we_d         = grant_b ? b_we    : a_we;
          addr_d       = grant_b ? b_addr  : a_addr;
          wdata_d      = grant_b ? b_wdata : a_wdata;
          cnt_d        = 3'd0;
          state_d      = (grant_b ? b_we : a_we) ? S_WS : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == WAIT_LAST) begin
          // Sample the selected lane on the edge that leaves RD.
          if (port_q == PORT_B) b_rdata_d = lane;
          else                  a_rdata_d = lane;
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WS: begin
        cnt_d   = 3'd0;
        state_d = S_WP;
      end
      S_WP: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 3'd0;
          state_d = S_WH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WH:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so every pin changes on
    // the same edge as the state it belongs to.
    bus_active = (state_d == S_RD) || (state_d == S_WS) ||
                 (state_d == S_WP) || (state_d == S_WH);
    sram_a_d   = bus_active ? addr_d[19:1] : sram_a_q;
    lbl_d      = !(bus_active && !addr_d[0]);
    ubl_d      = !(bus_active &&  addr_d[0]);
    wel_d      = (state_d != S_WP);
    d_oe_d     = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
    d_out_d    = {wdata_d, wdata_d};
    a_ack_d    = (state_d == S_DONE) && (port_d == PORT_A);
    b_ack_d    = (state_d == S_DONE) && (port_d == PORT_B);
  end

  // NOTE: state uses non-blocking assignments only, and the reset is tested
  // inside the clocked block, so it takes effect only at a clk edge.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      port_q       <= PORT_A;
      last_grant_q <= PORT_B;   // A wins the first tie
      we_q         <= 1'b0;
      addr_q       <= 20'd0;
      wdata_q      <= 8'd0;
      a_rdata_q    <= 8'd0;
      b_rdata_q    <= 8'd0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      sram_a_q     <= 19'd0;
      wel_q        <= 1'b1;
      lbl_q        <= 1'b1;
      ubl_q        <= 1'b1;
      d_oe_q       <= 1'b0;
      d_out_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      sram_a_q     <= sram_a_d;
      wel_q        <= wel_d;
      lbl_q        <= lbl_d;
      ubl_q        <= ubl_d;
      d_oe_q       <= d_oe_d;
      d_out_q      <= d_out_d;
    end
  end

  assign sram_d   = d_oe_q ? d_out_q : 16'hzzzz;
  assign sram_a   = sram_a_q;
  assign sram_wel = wel_q;
  assign sram_lbl = lbl_q;
  assign sram_ubl = ubl_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Three arbiter instances (wait_states 1, 0, 3), each attached to a small
// behavioural SRAM (64 words). The SRAM drives the bus during reads when
// rd_ok is set; probe forces it to drive 0 so a stray DUT driver shows up.
// Instance 0 (W=1) carries the functional scenarios; 1 and 2 the W sweep.
// Sample index n counts falling edges after the grant edge (n=1 is the first
// cycle of RD/WS).
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int NI   = 3;
  localparam int WV [NI] = '{1, 0, 3};
  localparam int MAXN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 n_reset;
  logic [NI-1:0]        a_req, a_we, b_req, b_we;
  logic [NI-1:0][19:0]  a_addr, b_addr;
  logic [NI-1:0][7:0]   a_wdata, b_wdata;
  wire  [NI-1:0][7:0]   a_rdata, b_rdata;
  wire  [NI-1:0]        a_ack, b_ack, sram_wel, sram_lbl, sram_ubl;
  wire  [NI-1:0][18:0]  sram_a;
  wire  [NI-1:0][15:0]  d_obs;
  logic [15:0]          mem [NI][64];
  logic [NI-1:0]        rd_ok, probe;

  int n_checks = 0;
  int n_fail   = 0;

  // per-cycle samples of the last run_access
  logic        s_wel [MAXN], s_lbl [MAXN], s_ubl [MAXN], s_ack [MAXN], s_oack [MAXN];
  logic [18:0] s_a [MAXN];
  logic [15:0] s_d [MAXN];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire [15:0] d;
    wire        drv = probe[g] ||
                      (rd_ok[g] && sram_wel[g] && !(sram_lbl[g] && sram_ubl[g]));
    assign d = drv ? (probe[g] ? 16'h0000 : mem[g][sram_a[g][5:0]]) : 16'hzzzz;
    assign d_obs[g] = d;

    sram_arbiter #(.wait_states(WV[g])) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .a_req    (a_req[g]),
      .a_we     (a_we[g]),
      .a_addr   (a_addr[g]),
      .a_wdata  (a_wdata[g]),
      .a_rdata  (a_rdata[g]),
      .a_ack    (a_ack[g]),
      .b_req    (b_req[g]),
      .b_we     (b_we[g]),
      .b_addr   (b_addr[g]),
      .b_wdata  (b_wdata[g]),
      .b_rdata  (b_rdata[g]),
      .b_ack    (b_ack[g]),
      .sram_a   (sram_a[g]),
      .sram_d   (d),
      .sram_wel (sram_wel[g]),
      .sram_lbl (sram_lbl[g]),
      .sram_ubl (sram_ubl[g])
    );
  end

  // SRAM write: latch the enabled lanes while wel is low
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!sram_wel[k]) begin
        if (!sram_lbl[k]) mem[k][sram_a[k][5:0]][7:0]  <= d_obs[k][7:0];
        if (!sram_ubl[k]) mem[k][sram_a[k][5:0]][15:8] <= d_obs[k][15:8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic preload(input int k, input int w, input logic [15:0] v);
    mem[k][w] <= v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    a_req = '0; b_req = '0; probe = '0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  // Issues one request on instance i at the current falling edge and samples
  // every cycle until the cycle after the ack (or until the bound expires).
  task automatic run_access(input int i, input bit pb, input bit we,
                            input logic [19:0] addr, input logic [7:0] wd,
                            output int ack_n);
    ack_n = 0;
    if (pb) begin
      b_we[i] = we; b_addr[i] = addr; b_wdata[i] = wd; b_req[i] = 1'b1;
    end else begin
      a_we[i] = we; a_addr[i] = addr; a_wdata[i] = wd; a_req[i] = 1'b1;
    end
    for (int n = 1; n < MAXN; n++) begin
      @(negedge clk);
      s_wel[n]  = sram_wel[i];
      s_lbl[n]  = sram_lbl[i];
      s_ubl[n]  = sram_ubl[i];
      s_a[n]    = sram_a[i];
      s_d[n]    = d_obs[i];
      s_ack[n]  = pb ? b_ack[i] : a_ack[i];
      s_oack[n] = pb ? a_ack[i] : b_ack[i];
      if (s_ack[n] && ack_n == 0) begin
        ack_n = n;
        if (pb) b_req[i] = 1'b0; else a_req[i] = 1'b0;
      end else if (ack_n != 0) begin
        break;
      end
    end
    if (ack_n == 0) begin
      a_req[i] = 1'b0; b_req[i] = 1'b0;
    end
  endtask

  function automatic int wel_low_cycles(input int last);
    int c = 0;
    for (int n = 1; n <= last && n < MAXN; n++) if (s_wel[n] === 1'b0) c++;
    return c;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_reset = 1'b0;
    a_req = '1; b_req = '1; a_we = '1; b_we = '1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({sram_wel[k], sram_lbl[k], sram_ubl[k]} !== 3'b111) begin
        n_fail++;
        $display("FAIL reset_enables[%0d]: got %b required 111", k,
                 {sram_wel[k], sram_lbl[k], sram_ubl[k]});
      end
      n_checks++;
      if (sram_a[k] !== 19'd0) begin
        n_fail++;
        $display("FAIL reset_addr[%0d]: got %h required 0", k, sram_a[k]);
      end
      n_checks++;
      if ({a_ack[k], b_ack[k], a_rdata[k], b_rdata[k]} !== 18'd0) begin
        n_fail++;
        $display("FAIL reset_port_outputs[%0d]: got %h required 0", k,
                 {a_ack[k], b_ack[k], a_rdata[k], b_rdata[k]});
      end
    end
    probe = '1;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (d_obs[k] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_bus_released[%0d]: got %h required 0000", k, d_obs[k]);
      end
    end
    probe = '0;
    a_req = '0; b_req = '0; a_we = '0; b_we = '0;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_read();
    int ackn;
    preload(0, 2, 16'hBEEF);
    rd_ok[0] = 1'b1;
    run_access(0, 1'b0, 1'b0, 20'h00004, 8'h00, ackn);
    n_checks++;
    if ({s_a[1], s_lbl[1], s_ubl[1], s_wel[1]} !== {19'd2, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_phase: got a=%h lbl=%b ubl=%b wel=%b required a=2 lbl=0 ubl=1 wel=1",
               s_a[1], s_lbl[1], s_ubl[1], s_wel[1]);
    end
    n_checks++;
    if (ackn !== 3) begin
      n_fail++;
      $display("FAIL rd_ack_latency: got %0d required 3", ackn);
    end
    n_checks++;
    if (s_ack[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_ack_width: got ack=%b after pulse required 0", s_ack[4]);
    end
    n_checks++;
    if (a_rdata[0] !== 8'hEF) begin
      n_fail++;
      $display("FAIL rd_data: got %h required EF", a_rdata[0]);
    end
    n_checks++;
    if ({s_oack[1], s_oack[2], s_oack[3], s_oack[4], b_rdata[0]} !== 12'h000) begin
      n_fail++;
      $display("FAIL rd_other_port_quiet: got b_ack/b_rdata %h required 000",
               {s_oack[1], s_oack[2], s_oack[3], s_oack[4], b_rdata[0]});
    end
  endtask

  task automatic test_write();
    int ackn;
    preload(0, 3, 16'h1234);
    rd_ok[0] = 1'b0;
    run_access(0, 1'b0, 1'b1, 20'h00007, 8'h5A, ackn);
    n_checks++;
    if ({s_wel[1], s_lbl[1], s_ubl[1], s_a[1], s_d[1]} !==
        {1'b1, 1'b1, 1'b0, 19'd3, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL wr_setup: got wel=%b lbl=%b ubl=%b a=%h d=%h required 1 1 0 3 5A5A",
               s_wel[1], s_lbl[1], s_ubl[1], s_a[1], s_d[1]);
    end
    for (int n = 2; n <= 3; n++) begin
      n_checks++;
      if ({s_wel[n], s_a[n], s_d[n]} !== {1'b0, 19'd3, 16'h5A5A}) begin
        n_fail++;
        $display("FAIL wr_pulse[%0d]: got wel=%b a=%h d=%h required 0 3 5A5A",
                 n, s_wel[n], s_a[n], s_d[n]);
      end
    end
    n_checks++;
    if ({s_wel[4], s_a[4], s_d[4]} !== {1'b1, 19'd3, 16'h5A5A}) begin
      n_fail++;
      $display("FAIL wr_hold: got wel=%b a=%h d=%h required 1 3 5A5A",
               s_wel[4], s_a[4], s_d[4]);
    end
    n_checks++;
    if (wel_low_cycles(ackn + 1) !== 2) begin
      n_fail++;
      $display("FAIL wr_wel_len: got %0d required 2", wel_low_cycles(ackn + 1));
    end
    n_checks++;
    if (ackn !== 5) begin
      n_fail++;
      $display("FAIL wr_ack_latency: got %0d required 5", ackn);
    end
    n_checks++;
    if ({s_lbl[5], s_ubl[5], s_wel[5]} !== 3'b111) begin
      n_fail++;
      $display("FAIL wr_done_idle_pins: got %b required 111", {s_lbl[5], s_ubl[5], s_wel[5]});
    end
    rd_ok[0] = 1'b1;
    run_access(0, 1'b0, 1'b0, 20'h00007, 8'h00, ackn);
    n_checks++;
    if (a_rdata[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL wr_readback_upper: got %h required 5A", a_rdata[0]);
    end
    run_access(0, 1'b0, 1'b0, 20'h00006, 8'h00, ackn);
    n_checks++;
    if (a_rdata[0] !== 8'h34) begin
      n_fail++;
      $display("FAIL wr_lower_untouched: got %h required 34", a_rdata[0]);
    end
  endtask

  task automatic test_round_robin();
    int nacks = 0;
    int tick [4];
    bit who [4];
    logic [7:0] brd [4];
    logic [7:0] ard [4];
    bool_dummy: begin end
    preload(0, 8, 16'h00A1);
    preload(0, 16, 16'hB200);
    rd_ok[0] = 1'b1;
    @(negedge clk);
    n_reset = 1'b0;
    a_req = '0; b_req = '0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    a_we[0] = 1'b0; a_addr[0] = 20'h00010; a_req[0] = 1'b1;
    b_we[0] = 1'b0; b_addr[0] = 20'h00021; b_req[0] = 1'b1;
    for (int t = 1; t <= 40 && nacks < 4; t++) begin
      @(negedge clk);
      if (a_ack[0] && b_ack[0]) begin
        n_checks++; n_fail++;
        $display("FAIL rr_dual_ack: got both acks at cycle %0d required one", t);
      end
      if (a_ack[0] || b_ack[0]) begin
        tick[nacks] = t; who[nacks] = b_ack[0];
        brd[nacks] = b_rdata[0]; ard[nacks] = a_rdata[0];
        nacks++;
      end
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    n_checks++;
    if (nacks !== 4) begin
      n_fail++;
      $display("FAIL rr_ack_count: got %0d required 4", nacks);
    end else begin
      n_checks++;
      if ({who[0], who[1], who[2], who[3]} !== 4'b0101) begin
        n_fail++;
        $display("FAIL rr_order: got %b (0=A) required 0101",
                 {who[0], who[1], who[2], who[3]});
      end
      n_checks++;
      if ({tick[0], tick[1], tick[2], tick[3]} !== {32'd3, 32'd7, 32'd11, 32'd15}) begin
        n_fail++;
        $display("FAIL rr_ack_times: got %0d %0d %0d %0d required 3 7 11 15",
                 tick[0], tick[1], tick[2], tick[3]);
      end
      n_checks++;
      if ({ard[0], brd[0], brd[1], brd[2], ard[2]} !== 40'hA1_00_B2_B2_A1) begin
        n_fail++;
        $display("FAIL rr_rdata: got %h required A100B2B2A1",
                 {ard[0], brd[0], brd[1], brd[2], ard[2]});
      end
    end
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    int btick [3];
    int atick = 0;
    do_reset();
    rd_ok[0] = 1'b1;
    b_we[0] = 1'b0; b_addr[0] = 20'h00021; b_req[0] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (a_ack[0]) begin
        atick = t;
        break;
      end
      if (b_ack[0]) begin
        if (nb < 3) btick[nb] = t;
        nb++;
        if (nb == 3) begin
          a_we[0] = 1'b0; a_addr[0] = 20'h00010; a_req[0] = 1'b1;
        end
      end
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    n_checks++;
    if (nb !== 3) begin
      n_fail++;
      $display("FAIL b2b_b_count: got %0d B acks before A required 3", nb);
    end else begin
      n_checks++;
      if ({btick[0], btick[1], btick[2]} !== {32'd3, 32'd7, 32'd11}) begin
        n_fail++;
        $display("FAIL b2b_b_times: got %0d %0d %0d required 3 7 11",
                 btick[0], btick[1], btick[2]);
      end
    end
    n_checks++;
    if (atick !== 15) begin
      n_fail++;
      $display("FAIL b2b_a_after_b: got A ack at %0d required 15", atick);
    end
    n_checks++;
    if (b_rdata[0] !== 8'hB2) begin
      n_fail++;
      $display("FAIL b2b_b_rdata: got %h required B2", b_rdata[0]);
    end
  endtask

  task automatic test_reset_mid_write();
    int ackn;
    bit saw_ack = 1'b0;
    do_reset();
    preload(0, 4, 16'h0000);
    rd_ok[0] = 1'b0;
    a_we[0] = 1'b1; a_addr[0] = 20'h00008; a_wdata[0] = 8'hC3; a_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sram_wel[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wp_entered: got wel=%b required 0", sram_wel[0]);
    end
    n_reset = 1'b0;
    a_req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({sram_wel[0], sram_lbl[0], sram_ubl[0], a_ack[0]} !== 4'b1110) begin
      n_fail++;
      $display("FAIL rst_wp_pins: got wel/lbl/ubl/ack=%b required 1110",
               {sram_wel[0], sram_lbl[0], sram_ubl[0], a_ack[0]});
    end
    probe[0] = 1'b1;
    #1;
    n_checks++;
    if (d_obs[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_wp_bus: got %h required 0000 (released)", d_obs[0]);
    end
    probe[0] = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (a_ack[0] || !sram_wel[0]) saw_ack = 1'b1;
    end
    n_checks++;
    if (saw_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wp_no_resume: got ack/wel activity required none");
    end
    run_access(0, 1'b0, 1'b1, 20'h00008, 8'hC3, ackn);
    n_checks++;
    if (ackn !== 5) begin
      n_fail++;
      $display("FAIL rst_reissue_ack: got %0d required 5", ackn);
    end
    rd_ok[0] = 1'b1;
    run_access(0, 1'b0, 1'b0, 20'h00008, 8'h00, ackn);
    n_checks++;
    if (a_rdata[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL rst_reissue_data: got %h required C3", a_rdata[0]);
    end
  endtask

  task automatic test_wait_sweep();
    int ackn;
    for (int k = 1; k < NI; k++) begin
      do_reset();
      rd_ok[k] = 1'b0;
      run_access(k, 1'b1, 1'b1, 20'h0000B, 8'h96, ackn);
      n_checks++;
      if (ackn !== WV[k] + 4) begin
        n_fail++;
        $display("FAIL sweep_wr_ack[W=%0d]: got %0d required %0d", WV[k], ackn, WV[k] + 4);
      end
      n_checks++;
      if (wel_low_cycles(ackn + 1) !== WV[k] + 1) begin
        n_fail++;
        $display("FAIL sweep_wel_len[W=%0d]: got %0d required %0d",
                 WV[k], wel_low_cycles(ackn + 1), WV[k] + 1);
      end
      rd_ok[k] = 1'b1;
      run_access(k, 1'b1, 1'b0, 20'h0000B, 8'h00, ackn);
      n_checks++;
      if (ackn !== WV[k] + 2) begin
        n_fail++;
        $display("FAIL sweep_rd_ack[W=%0d]: got %0d required %0d", WV[k], ackn, WV[k] + 2);
      end
      n_checks++;
      if (b_rdata[k] !== 8'h96) begin
        n_fail++;
        $display("FAIL sweep_rd_data[W=%0d]: got %h required 96", WV[k], b_rdata[k]);
      end
    end
  endtask

  initial begin
    n_reset = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    rd_ok = '0; probe = '0;
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 64; w++) mem[k][w] <= 16'h0000;

    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_write();
    test_wait_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
